// File: rtl/activity_record_tx.sv
// Per-net toggle counters over a fixed window, streamed out as records.
// Define ACT_TX_HEADER_EN to prefix each window with a {FF, seq} header.
module activity_record_tx #(
  parameter int NUM_NETS = 8,
  parameter int CNT_W    = 16,
  parameter int WINDOW   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_NETS-1:0]   net_in,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [8+CNT_W-1:0]    rec_data,
  output logic                  rec_last,
  output logic                  dropped
);

  localparam int WW = $clog2(WINDOW);
  localparam int SW = (NUM_NETS > 1) ? $clog2(NUM_NETS) : 1;
  localparam logic [7:0]       LAST = 8'(NUM_NETS - 1);
  localparam logic [WW-1:0]    WEND = WW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SEND
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [NUM_NETS-1:0] prev;
  logic [NUM_NETS-1:0] tog;
  logic [WW-1:0]       win;
  logic                win_end;
  logic                xfer;
  logic                take;
  logic [CNT_W-1:0]    cnt      [NUM_NETS];
  logic [CNT_W-1:0]    snap     [NUM_NETS];
  logic [CNT_W-1:0]    snap_new [NUM_NETS];
  logic [7:0]          idx;
  logic [7:0]          idx_n;
  logic [7:0]          idx_nxt;
  logic [SW-1:0]       sel;
  logic                valid_n;
  logic [8+CNT_W-1:0]  data_n;
  logic                last_n;
`ifdef ACT_TX_HEADER_EN
  logic [CNT_W-1:0]    seq;
`endif

  // Toggle detect, window end and snapshot-take decision.
  always_comb begin
    tog     = en ? (net_in ^ prev) : '0;
    win_end = en && (win == WEND);
    xfer    = rec_valid & rec_ready;
    take    = win_end &&
              ((state == IDLE) ||
               ((state == SEND) && xfer && (idx == LAST)));
    idx_nxt = idx + 8'd1;
    sel     = idx_nxt[SW-1:0];
  end

  // Saturating count including this cycle's toggle.
  always_comb begin
    for (int i = 0; i < NUM_NETS; i++) begin
      snap_new[i] = (tog[i] && (cnt[i] != CMAX)) ?
                    cnt[i] + CNT_W'(1) : cnt[i];
    end
  end

  // History, window counter, counters, snapshot and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      win     <= '0;
      dropped <= 1'b0;
      for (int i = 0; i < NUM_NETS; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      prev <= net_in;
      if (en) begin
        win <= win_end ? '0 : win + WW'(1);
      end
      if (win_end && !take) begin
        dropped <= 1'b1;
      end
      for (int i = 0; i < NUM_NETS; i++) begin
        if (en) begin
          cnt[i] <= win_end ? '0 : snap_new[i];
        end
        if (take) begin
          snap[i] <= snap_new[i];
        end
      end
    end
  end

`ifdef ACT_TX_HEADER_EN
  // Window sequence number, bumped per snapshot taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (take) begin
      seq <= seq + CNT_W'(1);
    end
  end
`endif

  // Stream FSM next state and next registered outputs.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = rec_valid;
    data_n  = rec_data;
    last_n  = rec_last;
    unique case (state)
      IDLE: begin
      end
`ifdef ACT_TX_HEADER_EN
      HDR: begin
        if (xfer) begin
          state_n = SEND;
          idx_n   = 8'd0;
          data_n  = {8'd0, snap[0]};
          last_n  = (LAST == 8'd0);
        end
      end
`endif
      SEND: begin
        if (xfer) begin
          if (idx == LAST) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            idx_n  = idx_nxt;
            data_n = {idx_nxt, snap[sel]};
            last_n = (idx_nxt == LAST);
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
    if (take) begin
      idx_n   = 8'd0;
      valid_n = 1'b1;
`ifdef ACT_TX_HEADER_EN
      state_n = HDR;
      data_n  = {8'hFF, seq};
      last_n  = 1'b0;
`else
      state_n = SEND;
      data_n  = {8'd0, snap_new[0]};
      last_n  = (LAST == 8'd0);
`endif
    end
  end

  // Stream state and registered record outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rec_valid <= 1'b0;
      rec_data  <= '0;
      rec_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rec_valid <= valid_n;
      rec_data  <= data_n;
      rec_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_activity_record_tx.sv
// Bench for activity_record_tx: phase table plus reference model
// feeding an expected-record queue, and hand-built corner sequences.
module tb_activity_record_tx;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int W  = 16;
  localparam int DW = 8 + CW;
`ifdef ACT_TX_HEADER_EN
  localparam int TOT = N + 1;
`else
  localparam int TOT = N;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  net_in = '0;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic [DW-1:0] rec_data;
  logic          rec_last;
  logic          dropped;

  always #5 clk = ~clk;

  activity_record_tx #(
    .NUM_NETS(N),
    .CNT_W(CW),
    .WINDOW(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .net_in(net_in),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_data(rec_data),
    .rec_last(rec_last),
    .dropped(dropped)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rec_t;

  typedef struct {
    string        name;
    int           cycles;
    logic [N-1:0] flip;
    bit           sparse;
    bit           rnd;
    bit           en;
    int           rmode;
  } phase_t;

  rec_t   exp_q[$];
  phase_t ph[7];
  int     checks = 0;
  int     errors = 0;

  logic [N-1:0]  m_prev;
  logic [CW-1:0] m_cnt [N];
  int            m_win;
  bit            m_busy;
  int            m_rem;
  bit            m_drop;
  logic [CW-1:0] m_seq;
  bit            hold;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_prev = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_win  = 0;
    m_busy = 0;
    m_rem  = 0;
    m_drop = 0;
    m_seq  = '0;
    hold   = 0;
    exp_q.delete();
  endtask

  // Called at a negedge: drive inputs, check outputs, advance model.
  task automatic step(input logic [N-1:0] n, input bit e, input bit r);
    logic [N-1:0]  tog;
    logic [CW-1:0] nc;
    bit            wend;
    bit            xfer;
    bit            take;
    rec_t          ex;
    net_in    = n;
    en        = e;
    rec_ready = r;
    chk("valid", rec_valid, m_busy);
    chk("dropped", dropped, m_drop);
    if (hold) begin
      chk("hold_data", rec_data, held_data);
      chk("hold_last", rec_last, held_last);
    end
    if (m_busy && r) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty actual=%0h required=none", rec_data);
      end else begin
        ex = exp_q.pop_front();
        chk("rec_data", rec_data, ex.data);
        chk("rec_last", rec_last, ex.last);
      end
    end
    tog  = e ? (n ^ m_prev) : '0;
    wend = e && (m_win == W - 1);
    xfer = m_busy && r;
    take = wend && (!m_busy || (xfer && m_rem == 1));
    if (xfer) begin
      m_rem--;
      if (m_rem == 0) m_busy = 0;
    end
    if (wend && !take) m_drop = 1;
    if (take) begin
`ifdef ACT_TX_HEADER_EN
      exp_q.push_back('{data: {8'hFF, m_seq}, last: 1'b0});
      m_seq = m_seq + 1'b1;
`endif
      m_busy = 1;
      m_rem  = TOT;
    end
    for (int i = 0; i < N; i++) begin
      nc = m_cnt[i];
      if (tog[i] && nc != {CW{1'b1}}) nc = nc + 1'b1;
      if (take) exp_q.push_back('{data: {8'(i), nc}, last: (i == N - 1)});
      if (e) m_cnt[i] = wend ? '0 : nc;
    end
    if (e) m_win = wend ? 0 : m_win + 1;
    m_prev    = n;
    hold      = rec_valid && !r;
    held_data = rec_data;
    held_last = rec_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input int p);
    logic [N-1:0] f;
    bit           r;
    for (int c = 0; c < ph[p].cycles; c++) begin
      f = ph[p].rnd ? N'($urandom) : ph[p].flip;
      if (ph[p].sparse && (c % 2 == 0)) f = '0;
      case (ph[p].rmode)
        0:       r = 1'b1;
        1:       r = 1'b0;
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      step(net_in ^ f, ph[p].en, r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    ph[0] = '{"toggle2", 40, 4'b0100, 1, 0, 1, 0};
    ph[1] = '{"sat",     48, 4'b0001, 0, 0, 1, 0};
    ph[2] = '{"rand",    64, 4'b0000, 0, 1, 1, 2};
    ph[3] = '{"enoff",   24, 4'b1111, 0, 0, 0, 0};
    ph[4] = '{"stall",   40, 4'b1010, 0, 0, 1, 1};
    ph[5] = '{"drain",   32, 4'b0110, 1, 0, 1, 0};
    ph[6] = '{"post",    48, 4'b1001, 0, 0, 1, 0};

    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_data", rec_data, '0);
    chk("rst_last", rec_last, 1'b0);
    chk("rst_dropped", dropped, 1'b0);
    rst_n = 1'b1;

    run_phase(0);
    run_phase(1);

    guard = 0;
    while (!(m_busy && m_rem == TOT && m_win == 0) && guard < 100) begin
      step(net_in ^ 4'b0010, 1'b1, 1'b1);
      guard++;
    end
    chk("align_wait", guard < 100, 1'b1);
    for (int k = 0; k < W; k++) begin
      step(net_in ^ 4'b0010, 1'b1, m_win >= W - TOT);
    end
    chk("align_valid", rec_valid, 1'b1);
`ifdef ACT_TX_HEADER_EN
    chk("align_first", rec_data[DW-1 -: 8], 8'hFF);
`else
    chk("align_first", rec_data[DW-1 -: 8], 8'h00);
`endif
    chk("align_dropped", dropped, 1'b0);

    run_phase(2);
    run_phase(3);
    run_phase(4);
    chk("stall_dropped", dropped, 1'b1);
    run_phase(5);

    guard = 0;
    while (!(m_busy && m_rem == N - 2) && guard < 100) begin
      step(net_in ^ 4'b1000, 1'b1, 1'b1);
      guard++;
    end
    chk("rst_wait", guard < 100, 1'b1);
    chk("pre_rst_idx", rec_data[DW-1 -: 8], 8'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rec_valid, 1'b0);
    chk("midrst_data", rec_data, '0);
    chk("midrst_last", rec_last, 1'b0);
    chk("midrst_dropped", dropped, 1'b0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
